// File: rtl/addsub_sched_if.sv
// Requester-side bundle for addsub_sched: two request/operand channels plus
// the shared response (done pulse, result, overflow) and status.
interface addsub_sched_if #(
    parameter int unsigned W     = 2,
    parameter int unsigned CNT_W = 8
);
    logic [1:0]       req;
    logic             op0;
    logic             op1;
    logic [W-1:0]     a0;
    logic [W-1:0]     a1;
    logic [W-1:0]     b0;
    logic [W-1:0]     b1;
    logic [1:0]       done;
    logic [W-1:0]     result;
    logic             ovf;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output req, op0, op1, a0, a1, b0, b1,
        input  done, result, ovf, busy, op_count
    );

    modport slave (
        input  req, op0, op1, a0, a1, b0, b1,
        output done, result, ovf, busy, op_count
    );
endinterface

// File: rtl/addsub_sched.sv
// Round-robin scheduler sharing one combinational add/sub unit between two
// requesters; one operation per three cycles (IDLE -> EXEC -> RESP).
module addsub_sched #(
    parameter int unsigned W     = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    addsub_sched_if.slave bus,
    output logic         alu_sel,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_d;
    logic   gnt;
    logic   last;
    logic   win_c;
    logic   ovf_c;
    logic [W:0] sum_c;
    logic [W:0] diff_c;

    // Next state and arbitration winner; on contention the requester that was
    // not served last wins.
    always_comb begin
        state_d = state;
        win_c   = 1'b0;
        unique case (bus.req)
            2'b10:   win_c = 1'b1;
            2'b11:   win_c = ~last;
            default: win_c = 1'b0;
        endcase
        case (state)
            IDLE:    if (bus.req != 2'b00) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Full-precision overflow on the latched operands: carry-out for add,
    // signed W-bit range violation (top two difference bits disagree) for sub.
    always_comb begin
        sum_c  = {1'b0, alu_a} + {1'b0, alu_b};
        diff_c = {1'b0, alu_a} - {1'b0, alu_b};
        ovf_c  = alu_sel ? (diff_c[W] ^ diff_c[W-1]) : sum_c[W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            last         <= 1'b1;
            alu_sel      <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            bus.done     <= 2'b00;
            bus.result   <= '0;
            bus.ovf      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.op_count <= '0;
        end else begin
            state    <= state_d;
            bus.busy <= (state_d != IDLE);
            bus.done <= 2'b00;
            case (state)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        gnt     <= win_c;
                        alu_sel <= win_c ? bus.op1 : bus.op0;
                        alu_a   <= win_c ? bus.a1  : bus.a0;
                        alu_b   <= win_c ? bus.b1  : bus.b0;
                    end
                end
                EXEC: begin
                    bus.result <= alu_o;
                    bus.ovf    <= ovf_c;
                end
                RESP: begin
                    bus.done     <= gnt ? 2'b10 : 2'b01;
                    bus.op_count <= bus.op_count + CNT_W'(1);
                    last         <= gnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_sched.sv
// Scoreboard bench for addsub_sched: stimulus pushes expected responses, a
// negedge monitor pops and compares on every done pulse.
module tb_addsub_sched;
    localparam int unsigned W     = 2;
    localparam int unsigned CNT_W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         alu_sel;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_o;

    addsub_sched_if #(.W(W), .CNT_W(CNT_W)) bus ();

    addsub_sched #(.W(W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_sel (alu_sel),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_o   (alu_o)
    );

    // The shared 2-bit adder/subtractor
    assign alu_o = alu_sel ? W'(alu_a - alu_b) : W'(alu_a + alu_b);

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       done;
        logic [W-1:0]     res;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] res, input logic ovf);
        exp_t e;
        exp_count++;
        e.done = (id == 1) ? 2'b10 : 2'b01;
        e.res  = res;
        e.ovf  = ovf;
        e.cnt  = CNT_W'(exp_count);
        sbq.push_back(e);
    endtask

    function automatic void model(input logic op, input int a, input int b,
                                  output logic [W-1:0] r, output logic v);
        int s;
        if (!op) begin
            s = a + b;
            v = (s > 3);
        end else begin
            s = a - b;
            v = (s < -2) || (s > 1);
        end
        r = W'(s & 3);
    endfunction

    task automatic set_req(input int id, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req[0] = 1'b1;
        end else begin
            bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req[1] = 1'b1;
        end
    endtask

    // Single uncontended operation; operands are scrambled after grant.
    task automatic run_op(input int id, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ev);
        int lat;
        push_exp(id, er, ev);
        set_req(id, op, a, b);
        @(posedge clk); #1;
        check("exec_busy", 32'(bus.busy), 1);
        check("exec_alu_sel", 32'(alu_sel), 32'(op));
        check("exec_alu_a", 32'(alu_a), 32'(a));
        check("exec_alu_b", 32'(alu_b), 32'(b));
        if (id == 0) begin
            bus.a0 = ~a; bus.b0 = ~b; bus.op0 = ~op;
        end else begin
            bus.a1 = ~a; bus.b1 = ~b; bus.op1 = ~op;
        end
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.done[id]) begin
                lat = i;
                break;
            end
        end
        check("done_latency", 32'(lat), 3);
        bus.req[id] = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done != 2'b00) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 0);
            end else begin
                e = sbq.pop_front();
                check("done_id", 32'(bus.done), 32'(e.done));
                check("result", 32'(bus.result), 32'(e.res));
                check("ovf", 32'(bus.ovf), 32'(e.ovf));
                check("op_count", 32'(bus.op_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]   trace;
        logic [1:0]   seen;
        logic [W-1:0] r;
        logic         v;

        rst = 1'b1;
        bus.req = 2'b00;
        bus.op0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.op1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(bus.done), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_op_count", 32'(bus.op_count), 0);
        check("rst_alu_sel", 32'(alu_sel), 0);
        rst = 1'b0;

        // Reset during EXEC discards the operation
        set_req(0, 1'b1, 2'd1, 2'd2);
        @(posedge clk); #1;
        check("midrst_exec_busy", 32'(bus.busy), 1);
        check("midrst_exec_alu_a", 32'(alu_a), 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_alu_sel", 32'(alu_sel), 0);
        check("midrst_alu_a", 32'(alu_a), 0);
        check("midrst_alu_b", 32'(alu_b), 0);
        check("midrst_done", 32'(bus.done), 0);
        bus.req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        seen = 2'b00;
        repeat (6) begin
            @(negedge clk);
            seen |= bus.done;
        end
        check("midrst_no_done", 32'(seen), 0);
        check("midrst_idle_busy", 32'(bus.busy), 0);

        // Directed single operations with hand-computed results
        run_op(0, 1'b0, 2'd1, 2'd2, 2'd3, 1'b0);
        run_op(0, 1'b0, 2'd3, 2'd2, 2'd1, 1'b1);
        run_op(0, 1'b1, 2'd0, 2'd3, 2'd1, 1'b1);
        run_op(1, 1'b1, 2'd1, 2'd3, 2'd2, 1'b0);

        // Contention: last grant was 1, so order is 0,1,0
        push_exp(0, 2'd2, 1'b1);
        push_exp(1, 2'd3, 1'b0);
        push_exp(0, 2'd2, 1'b1);
        bus.op0 = 1'b1; bus.a0 = 2'd3; bus.b0 = 2'd1;
        bus.op1 = 1'b0; bus.a1 = 2'd2; bus.b1 = 2'd1;
        bus.req = 2'b11;
        @(posedge clk);
        trace = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            trace = {trace[7:0], bus.busy};
        end
        check("contention_busy_trace", 32'(trace), 32'(9'b110110110));
        check("contention_last_done", 32'(bus.done), 32'(2'b01));
        bus.req = 2'b00;

        // Fresh reset, then all 32 (op,a,b) through requester 1
        @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        for (int op = 0; op < 2; op++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    model(1'(op), a, b, r, v);
                    run_op(1, 1'(op), W'(a), W'(b), r, v);
                end
            end
        end
        repeat (3) @(negedge clk);
        check("final_op_count", 32'(bus.op_count), 32);
        check("sb_empty", 32'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
